// File: rtl/sample_output_serializer.sv
// Sample output serializer: buffers mono samples in a small FIFO and sends
// each one to a stereo DAC as a left-justified frame. The same sample goes
// to both the left and the right slot.
module sample_output_serializer #(
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_SampleReady,
  input  logic [15:0]                   i_Sample,
  input  logic                          i_ClearStatus,
  output logic                          o_BitClock,
  output logic                          o_LRClock,
  output logic                          o_SerialData,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
  output logic                          o_Overflow,
  output logic                          o_Underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_idx;
  logic [4:0]       bit_idx_next;
  // Bits still to be sent after the one currently on o_SerialData; together
  // with o_SerialData this forms the 32-bit frame shift register.
  logic [30:0]      shift_rest;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      head_sample;

  logic div_tc;
  logic fall_evt;
  logic frame_load;
  logic fifo_empty;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic drop_evt;
  logic starve_evt;

  assign div_tc       = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_evt     = div_tc & o_BitClock;
  assign bit_idx_next = bit_idx + 5'd1;
  assign frame_load   = fall_evt & (bit_idx == 5'd31);

  assign fifo_empty   = (o_FifoLevel == '0);
  assign fifo_full    = (o_FifoLevel == LVL_W'(FIFO_DEPTH));
  assign head_sample  = fifo_mem[rd_ptr];

  // A full FIFO still accepts a push when the same cycle pops the head.
  assign do_pop       = frame_load & ~fifo_empty;
  assign do_push      = i_SampleReady & (~fifo_full | do_pop);
  assign drop_evt     = i_SampleReady & fifo_full & ~do_pop;
  assign starve_evt   = frame_load & fifo_empty;

  // Bit-clock divider: toggle the bit clock each time the counter wraps.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      div_cnt    <= '0;
      o_BitClock <= 1'b0;
    end else if (div_tc) begin
      div_cnt    <= '0;
      o_BitClock <= ~o_BitClock;
    end else begin
      div_cnt    <= div_cnt + DIV_W'(1);
    end
  end

  // Serial side: advance bit index, LR clock and data on each falling edge.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bit_idx      <= 5'd31;
      o_LRClock    <= 1'b0;
      o_SerialData <= 1'b0;
      shift_rest   <= '0;
    end else if (fall_evt) begin
      bit_idx   <= bit_idx_next;
      o_LRClock <= bit_idx_next[4];
      if (frame_load) begin
        if (!fifo_empty) begin
          o_SerialData <= head_sample[15];
          shift_rest   <= {head_sample[14:0], head_sample};
        end else begin
          o_SerialData <= 1'b0;
          shift_rest   <= '0;
        end
      end else begin
        o_SerialData <= shift_rest[30];
        shift_rest   <= {shift_rest[29:0], 1'b0};
      end
    end
  end

  // FIFO storage: write the incoming sample at the tail.
  always_ff @(posedge i_Clock) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= i_Sample;
    end
  end

  // FIFO pointers and occupancy; drops and starves leave them untouched.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_FifoLevel <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   o_FifoLevel <= o_FifoLevel + LVL_W'(1);
        2'b01:   o_FifoLevel <= o_FifoLevel - LVL_W'(1);
        default: o_FifoLevel <= o_FifoLevel;
      endcase
    end
  end

  // Sticky status flags; a new event outranks a simultaneous clear.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (drop_evt) begin
        o_Overflow <= 1'b1;
      end else if (i_ClearStatus) begin
        o_Overflow <= 1'b0;
      end
      if (starve_evt) begin
        o_Underflow <= 1'b1;
      end else if (i_ClearStatus) begin
        o_Underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_output_serializer.sv
// Self-checking bench for sample_output_serializer (FIFO_DEPTH=8, BCLK_DIV=2).
module tb_sample_output_serializer;

  localparam int FD    = 8;
  localparam int BD    = 2;
  localparam int FRAME = 64 * BD;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n;
  logic        i_SampleReady;
  logic [15:0] i_Sample;
  logic        i_ClearStatus;
  logic        o_BitClock;
  logic        o_LRClock;
  logic        o_SerialData;
  logic [3:0]  o_FifoLevel;
  logic        o_Overflow;
  logic        o_Underflow;

  sample_output_serializer #(.FIFO_DEPTH(FD), .BCLK_DIV(BD)) dut (
    .i_Clock       (i_Clock),
    .i_Reset_n     (i_Reset_n),
    .i_SampleReady (i_SampleReady),
    .i_Sample      (i_Sample),
    .i_ClearStatus (i_ClearStatus),
    .o_BitClock    (o_BitClock),
    .o_LRClock     (o_LRClock),
    .o_SerialData  (o_SerialData),
    .o_FifoLevel   (o_FifoLevel),
    .o_Overflow    (o_Overflow),
    .o_Underflow   (o_Underflow)
  );

  always #5 i_Clock = ~i_Clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          c        = 0;     // clock edges since reset release
  logic [15:0] mq[$];            // bench model of FIFO contents
  logic [15:0] ef[$];            // expected frames (0 for a starved frame)
  logic        exp_ovf  = 1'b0;
  logic        exp_unf  = 1'b0;
  logic        started  = 1'b0;
  logic        prev_bclk = 1'b0;
  int          nbits    = 0;
  logic [31:0] cap      = '0;

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [3:0]  exp_level;
    logic        exp_ovf;
  } burst_t;
  burst_t vec[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, c);
  endtask

  // Reference behaviour, derived from frame timing and FIFO rules.
  always @(posedge i_Clock) begin : model
    logic        ld;
    logic        pop;
    logic        push_ok;
    int          f;
    logic        e_bclk;
    logic        e_lr;
    logic [15:0] e;
    if (!i_Reset_n) begin
      c = 0;
    end else begin
      c++;
      ld      = ((c % FRAME) == 2 * BD);
      pop     = ld && (mq.size() > 0);
      push_ok = i_SampleReady && ((mq.size() < FD) || pop);
      if (ld) begin
        started = 1'b1;
        if (pop) ef.push_back(mq.pop_front());
        else     ef.push_back(16'h0000);
      end
      if (push_ok) mq.push_back(i_Sample);
      if (i_SampleReady && !push_ok) exp_ovf = 1'b1;
      else if (i_ClearStatus)        exp_ovf = 1'b0;
      if (ld && !pop)                exp_unf = 1'b1;
      else if (i_ClearStatus)        exp_unf = 1'b0;
    end
    #1;
    if (i_Reset_n && c > 0) begin
      f      = c / (2 * BD);
      e_bclk = ((c / BD) % 2) == 1;
      e_lr   = (f == 0) ? 1'b0 : (((f - 1) % 32) >= 16);
      chk("cycle", {24'b0, o_BitClock, o_LRClock, o_FifoLevel, o_Overflow, o_Underflow},
                   {24'b0, e_bclk, e_lr, 4'(mq.size()), exp_ovf, exp_unf});
      if (o_BitClock && !prev_bclk && started) begin
        cap = {cap[30:0], o_SerialData};
        nbits++;
        if (nbits == 32) begin
          if (ef.size() == 0) chk("frame_avail", ef.size(), 1);
          else begin
            e = ef.pop_front();
            chk("frame", cap, {e, e});
          end
          nbits = 0;
        end
      end
    end
    prev_bclk = o_BitClock;
  end

  task automatic do_reset();
    i_Reset_n = 1'b0;
    #1;
    chk("reset_outputs", {23'b0, o_BitClock, o_LRClock, o_SerialData, o_FifoLevel, o_Overflow, o_Underflow}, 32'h0);
    mq.delete();
    ef.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    started = 1'b0;
    nbits   = 0;
    cap     = '0;
    prev_bclk = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_Reset_n = 1'b1;
  endtask

  // Return at the falling clock edge just before edge n.
  task automatic at_edge(input int n);
    int g;
    g = 0;
    while (c < n - 1 && g < 20000) begin
      @(negedge i_Clock);
      g++;
    end
    if (c != n - 1) chk("at_edge", c, n - 1);
  endtask

  task automatic push(input logic [15:0] v);
    i_SampleReady = 1'b1;
    i_Sample      = v;
    @(negedge i_Clock);
    i_SampleReady = 1'b0;
  endtask

  initial begin
    i_Reset_n     = 1'b1;
    i_SampleReady = 1'b0;
    i_Sample      = '0;
    i_ClearStatus = 1'b0;
    vec[0] = '{n: 1,  base: 16'hA5C3, exp_level: 4'd1, exp_ovf: 1'b0};
    vec[1] = '{n: 3,  base: 16'h8000, exp_level: 4'd3, exp_ovf: 1'b0};
    vec[2] = '{n: 8,  base: 16'h1234, exp_level: 4'd8, exp_ovf: 1'b0};
    vec[3] = '{n: 9,  base: 16'h0001, exp_level: 4'd8, exp_ovf: 1'b1};
    vec[4] = '{n: 11, base: 16'hFFF0, exp_level: 4'd8, exp_ovf: 1'b1};
    #2;
    do_reset();

    // Idle: zero frames, underflow set by the first load at edge 4.
    at_edge(4);
    chk("idle_unf_before", {31'b0, o_Underflow}, 32'd0);
    @(negedge i_Clock);
    chk("idle_unf_after", {31'b0, o_Underflow}, 32'd1);
    chk("idle_sdata", {31'b0, o_SerialData}, 32'd0);
    at_edge(2 * FRAME + 10);

    // Single sample before the first load.
    do_reset();
    push(16'hA5C3);
    at_edge(4);
    chk("single_level_pre", {28'b0, o_FifoLevel}, 32'd1);
    @(negedge i_Clock);
    chk("single_level_post", {28'b0, o_FifoLevel}, 32'd0);
    chk("single_unf", {31'b0, o_Underflow}, 32'd0);
    chk("single_first_bit", {31'b0, o_SerialData}, 32'd1);
    at_edge(3 * FRAME + 10);

    // Burst table: pushes land mid-frame, then frames drain the FIFO.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      at_edge(5);
      for (int k = 0; k < vec[i].n; k++) push(vec[i].base + 16'(k));
      chk("burst_level", {28'b0, o_FifoLevel}, {28'b0, vec[i].exp_level});
      chk("burst_ovf", {31'b0, o_Overflow}, {31'b0, vec[i].exp_ovf});
      at_edge(4 + (((vec[i].n > FD) ? FD : vec[i].n) + 2) * FRAME);
    end

    // Full FIFO with a push exactly in the load cycle.
    do_reset();
    at_edge(5);
    for (int k = 1; k <= FD; k++) push(16'h0100 + 16'(k));
    chk("full_level", {28'b0, o_FifoLevel}, 32'd8);
    at_edge(FRAME + 2 * BD);
    push(16'h7FFF);
    chk("pushpop_level", {28'b0, o_FifoLevel}, 32'd8);
    chk("pushpop_ovf", {31'b0, o_Overflow}, 32'd0);
    at_edge(4 + 10 * FRAME);

    // Clear coinciding with an underflow load, then a later clear.
    do_reset();
    at_edge(4);
    i_ClearStatus = 1'b1;
    @(negedge i_Clock);
    i_ClearStatus = 1'b0;
    chk("clr_vs_set", {31'b0, o_Underflow}, 32'd1);
    i_ClearStatus = 1'b1;
    @(negedge i_Clock);
    i_ClearStatus = 1'b0;
    chk("clr_later", {31'b0, o_Underflow}, 32'd0);
    at_edge(FRAME + 10);

    // Asynchronous reset in the right slot (b = 20) with 3 entries queued.
    do_reset();
    push(16'hFFFF);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    at_edge(85);
    chk("mid_level", {28'b0, o_FifoLevel}, 32'd3);
    chk("mid_lr", {31'b0, o_LRClock}, 32'd1);
    chk("mid_sdata", {31'b0, o_SerialData}, 32'd1);
    do_reset();
    at_edge(4);
    chk("post_rst_level", {28'b0, o_FifoLevel}, 32'd0);
    chk("post_rst_unf_pre", {31'b0, o_Underflow}, 32'd0);
    @(negedge i_Clock);
    chk("post_rst_unf", {31'b0, o_Underflow}, 32'd1);
    at_edge(2 * FRAME + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_output_serializer.md
Name: sample_output_serializer

Overview:
- Consumes the mixed-sample stream (one-cycle ready strobe plus 16-bit signed sample) from the sample generation stage.
- Buffers samples in a small FIFO to decouple the synthesis rate from the audio frame rate.
- Serializes each sample to a stereo DAC as a left-justified I2S-family stream (bit clock, LR clock, data), duplicating the mono sample on both channels.
- Sits at the output boundary of the synth core, driving the DAC pins.

Parameters:
FIFO_DEPTH, 8, sample FIFO entries; power of two, 2..64.
BCLK_DIV, 4, i_Clock cycles per bit-clock half period; >= 1.

Ports:
i_Clock  input  1  system clock.
i_Reset_n  input  1  asynchronous active-low reset.
i_SampleReady  input  1  one-cycle strobe: i_Sample is valid this cycle.
i_Sample  input  16  signed two's-complement sample.
i_ClearStatus  input  1  clears sticky o_Overflow / o_Underflow.
o_BitClock  output  1  serial bit clock to DAC.
o_LRClock  output  1  channel select: 0 = left, 1 = right.
o_SerialData  output  1  serial data, MSB first.
o_FifoLevel  output  $clog2(FIFO_DEPTH)+1  entries currently held.
o_Overflow  output  1  sticky: a sample was dropped because the FIFO was full.
o_Underflow  output  1  sticky: a frame started with the FIFO empty.

Behaviour:
Reset (async assert, sync release):
- All outputs are 0; FIFO empty; divider count 0; bit index b = 31; shift register 0.

Divider:
- Counter runs 0..BCLK_DIV-1; at terminal count it wraps and toggles o_BitClock.
- Period of o_BitClock is 2*BCLK_DIV clocks; first rising edge is BCLK_DIV cycles after reset release.
- A "falling event" is the cycle in which o_BitClock is registered 1 -> 0. Every serial update happens only on a falling event; the DAC samples on the rising edge.

Bit index:
- On each falling event, b <= (b+1) mod 32.
- o_LRClock <= 1 when the new b >= 16, else 0.

Frame load (falling event where b wraps 31 -> 0):
- FIFO non-empty: pop the head sample S. Shift register <= {S, S}; o_SerialData <= S[15].
- FIFO empty: shift register <= 0; o_SerialData <= 0; set o_Underflow.

Other falling events:
- Shift register shifts left by one.
- o_SerialData <= the new MSB.

Frame layout:
- Left channel (o_LRClock = 0) occupies b = 0..15, MSB first.
- Right channel (o_LRClock = 1) occupies b = 16..31.
- One frame = 64*BCLK_DIV clocks.
- First load occurs at the first falling event after reset, i.e. 2*BCLK_DIV cycles after release.

FIFO:
- i_SampleReady while not full: write i_Sample at the tail.
- i_SampleReady while full and no pop this cycle: sample dropped, FIFO unchanged, o_Overflow set.
- Push and pop in the same cycle when full: both succeed; level unchanged.
- Push in the same cycle as a frame load on an empty FIFO: no bypass. Zeros are sent, underflow is set, and the pushed sample is stored for the next frame.
- o_FifoLevel is registered and reflects the post-update occupancy. It wraps neither up nor down; underflow and overflow never corrupt the pointers.

Status:
- o_Overflow and o_Underflow remain set until a cycle with i_ClearStatus = 1.
- If a set event and i_ClearStatus coincide, set wins.

Reset mid-frame:
- Immediately returns to the reset state: all outputs 0, FIFO contents discarded.
- The next frame starts cleanly at b = 0 after release.

Constraints:
- Only i_Sample bits are serialized; there is no sign extension or scaling.
- All outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- Reset and idle, BCLK_DIV=2, no input -> o_BitClock toggles every 2 clocks; o_LRClock low for 16 bit periods, then high for 16; o_SerialData stays 0; o_Underflow = 1 after the first load at cycle 4.
- Single sample: push 16'hA5C3 before the first load -> left and right slots each shift out 1010_0101_1100_0011 MSB first; the following frame is all zeros and sets underflow; o_FifoLevel goes 1 -> 0 at the load.
- Overflow: FIFO_DEPTH=8, 9 back-to-back pushes 16'h0001..16'h0009 with no load -> o_FifoLevel = 8, o_Overflow = 1; frames then emit 0001..0008 in order and 0009 is never seen.
- Full push+pop coincident: FIFO full, push 16'h7FFF in the exact load cycle -> level stays 8, no overflow, 16'h7FFF is transmitted as the eighth frame after.
- Clear vs set: i_ClearStatus asserted in the same cycle as an underflow load -> o_Underflow remains 1; clear one cycle later -> 0.
- Async reset mid-frame at b = 20 with 3 entries queued -> all outputs 0 within the reset assertion; after release the first frame is zeros with underflow set, and o_FifoLevel = 0.
